// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Operands are registered on grant, evaluated for one cycle, and the result is held on a tagged response channel.
module alu_arbiter #(
    parameter int XLEN  = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic [13:0]     req0_ctl,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    input  logic [13:0]     req1_ctl,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_negative,
    output logic            rsp_zero,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_op,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_negative,
    input  logic            alu_zero,
    output logic [1:0]      dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Handshakes: a transfer happens in a cycle where valid and ready are both 1.
    // reqN_ready depends combinationally on reqN_valid; rsp_valid is held until rsp_ready.

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] in1_q, in1_d;
    logic [XLEN-1:0] in2_q, in2_d;
    logic [13:0]     ctl_q, ctl_d;
    logic            op_id_q, op_id_d;
    logic            last_grant_q, last_grant_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;
    logic            rsp_neg_q, rsp_neg_d;
    logic            rsp_zero_q, rsp_zero_d;

    logic window;
    logic gnt0;
    logic gnt1;

    // A new op may start when idle, or in the same cycle the held response is consumed.
    assign window = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
    assign gnt1   = window && req1_valid && (!req0_valid || (RR_EN && !last_grant_q));
    assign gnt0   = window && req0_valid && !gnt1;

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_negative = rsp_neg_q;
    assign rsp_zero     = rsp_zero_q;
    assign alu_in1      = in1_q;
    assign alu_in2      = in2_q;
    assign alu_op       = ctl_q[3:0];
    assign alu_funct3   = ctl_q[6:4];
    assign alu_funct7   = ctl_q[13:7];
    assign dbg_state_o  = state_q;

    always_comb begin
        state_d      = state_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        ctl_d        = ctl_q;
        op_id_d      = op_id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_neg_d    = rsp_neg_q;
        rsp_zero_d   = rsp_zero_q;

        if (gnt0 || gnt1) begin
            in1_d        = gnt1 ? req1_in1 : req0_in1;
            in2_d        = gnt1 ? req1_in2 : req0_in2;
            ctl_d        = gnt1 ? req1_ctl : req0_ctl;
            op_id_d      = gnt1;
            last_grant_d = gnt1;
        end

        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_result_d = alu_result;
                rsp_neg_d    = alu_negative;
                rsp_zero_d   = alu_zero;
                rsp_id_d     = op_id_q;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = (gnt0 || gnt1) ? S_EXEC : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in1_q        <= '0;
            in2_q        <= '0;
            ctl_q        <= '0;
            op_id_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_neg_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            ctl_q        <= ctl_d;
            op_id_q      <= op_id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_neg_q    <= rsp_neg_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority instance,
// each wired to a small behavioural ALU (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra).
module tb_alu_arbiter;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    // Round-robin instance signals
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [31:0] r0_in1, r0_in2, r1_in1, r1_in2;
    logic [13:0] r0_ctl, r1_ctl;
    logic        r_rsp_valid, r_rsp_ready, r_rsp_id, r_rsp_neg, r_rsp_zero;
    logic [31:0] r_rsp_result;
    logic [31:0] r_alu_in1, r_alu_in2, r_alu_result;
    logic [3:0]  r_alu_op;
    logic [2:0]  r_alu_funct3;
    logic [6:0]  r_alu_funct7;
    logic        r_alu_neg, r_alu_zero;
    logic [1:0]  r_state;

    // Fixed-priority instance signals
    logic        f0_valid, f0_ready, f1_valid, f1_ready;
    logic [31:0] f0_in1, f0_in2, f1_in1, f1_in2;
    logic [13:0] f0_ctl, f1_ctl;
    logic        f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_neg, f_rsp_zero;
    logic [31:0] f_rsp_result;
    logic [31:0] f_alu_in1, f_alu_in2, f_alu_result;
    logic [3:0]  f_alu_op;
    logic [2:0]  f_alu_funct3;
    logic [6:0]  f_alu_funct7;
    logic        f_alu_neg, f_alu_zero;
    logic [1:0]  f_state;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        r_alu_result = alu_f(r_alu_in1, r_alu_in2, r_alu_op);
        r_alu_neg    = r_alu_result[31];
        r_alu_zero   = (r_alu_result == 32'd0);
        f_alu_result = alu_f(f_alu_in1, f_alu_in2, f_alu_op);
        f_alu_neg    = f_alu_result[31];
        f_alu_zero   = (f_alu_result == 32'd0);
    end

    alu_arbiter #(.XLEN(32), .RR_EN(1'b1)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0_valid), .req0_ready(r0_ready),
        .req0_in1(r0_in1), .req0_in2(r0_in2), .req0_ctl(r0_ctl),
        .req1_valid(r1_valid), .req1_ready(r1_ready),
        .req1_in1(r1_in1), .req1_in2(r1_in2), .req1_ctl(r1_ctl),
        .rsp_valid(r_rsp_valid), .rsp_ready(r_rsp_ready), .rsp_id(r_rsp_id),
        .rsp_result(r_rsp_result), .rsp_negative(r_rsp_neg), .rsp_zero(r_rsp_zero),
        .alu_in1(r_alu_in1), .alu_in2(r_alu_in2), .alu_op(r_alu_op),
        .alu_funct3(r_alu_funct3), .alu_funct7(r_alu_funct7),
        .alu_result(r_alu_result), .alu_negative(r_alu_neg), .alu_zero(r_alu_zero),
        .dbg_state_o(r_state)
    );

    alu_arbiter #(.XLEN(32), .RR_EN(1'b0)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f0_valid), .req0_ready(f0_ready),
        .req0_in1(f0_in1), .req0_in2(f0_in2), .req0_ctl(f0_ctl),
        .req1_valid(f1_valid), .req1_ready(f1_ready),
        .req1_in1(f1_in1), .req1_in2(f1_in2), .req1_ctl(f1_ctl),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
        .rsp_result(f_rsp_result), .rsp_negative(f_rsp_neg), .rsp_zero(f_rsp_zero),
        .alu_in1(f_alu_in1), .alu_in2(f_alu_in2), .alu_op(f_alu_op),
        .alu_funct3(f_alu_funct3), .alu_funct7(f_alu_funct7),
        .alu_result(f_alu_result), .alu_negative(f_alu_neg), .alu_zero(f_alu_zero),
        .dbg_state_o(f_state)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drive_r0(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [6:0] f7);
        r0_valid = v;
        r0_in1   = a;
        r0_in2   = b;
        r0_ctl   = {f7, 3'd0, op};
    endtask

    task automatic drive_r1(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op);
        r1_valid = v;
        r1_in1   = a;
        r1_in2   = b;
        r1_ctl   = {7'd0, 3'd0, op};
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] res,
                             input logic neg, input logic zero);
        check({tag, "_valid"}, 32'(r_rsp_valid), 32'd1);
        check({tag, "_id"},    32'(r_rsp_id),    32'(id));
        check({tag, "_result"}, r_rsp_result,    res);
        check({tag, "_neg"},   32'(r_rsp_neg),   32'(neg));
        check({tag, "_zero"},  32'(r_rsp_zero),  32'(zero));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive_r0(1'b0, 32'd0, 32'd0, 4'd0, 7'd0);
        drive_r1(1'b0, 32'd0, 32'd0, 4'd0);
        r_rsp_ready = 1'b0;
        f0_valid = 1'b0; f0_in1 = 32'd0; f0_in2 = 32'd0; f0_ctl = 14'd0;
        f1_valid = 1'b0; f1_in1 = 32'd0; f1_in2 = 32'd0; f1_ctl = 14'd0;
        f_rsp_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_state", 32'(r_state), 32'd0);
        check("rst_rsp_valid", 32'(r_rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(r_rsp_id), 32'd0);
        check("rst_alu_in1", r_alu_in1, 32'd0);
        check("rst_rsp_result", r_rsp_result, 32'd0);

        // req0 add 0x0F + 0xF0
        drive_r0(1'b1, 32'h0000_000F, 32'h0000_00F0, 4'd0, 7'd0);
        #1;
        check("add_r0_ready", 32'(r0_ready), 32'd1);
        check("add_r1_ready", 32'(r1_ready), 32'd0);
        step();
        drive_r0(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd4, 7'd0);
        check("add_exec_state", 32'(r_state), 32'd1);
        check("add_alu_in1_reg", r_alu_in1, 32'h0000_000F);
        check("add_exec_rsp_valid", 32'(r_rsp_valid), 32'd0);
        step();
        check_rsp("add", 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
        r_rsp_ready = 1'b1;
        step();
        r_rsp_ready = 1'b0;
        check("add_done_valid", 32'(r_rsp_valid), 32'd0);
        check("add_done_state", 32'(r_state), 32'd0);

        // req1 sub 0 - 1
        drive_r1(1'b1, 32'd0, 32'd1, 4'd1);
        #1;
        check("sub_r1_ready", 32'(r1_ready), 32'd1);
        step();
        drive_r1(1'b0, 32'd0, 32'd0, 4'd0);
        step();
        check_rsp("sub", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        r_rsp_ready = 1'b1;
        step();
        r_rsp_ready = 1'b0;

        // Both valid after reset: req0 first, req1 back-to-back in RESP
        do_reset();
        drive_r0(1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd3, 7'd0);
        drive_r1(1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd2);
        #1;
        check("rr_first_r0_ready", 32'(r0_ready), 32'd1);
        check("rr_first_r1_ready", 32'(r1_ready), 32'd0);
        step();
        drive_r0(1'b0, 32'd0, 32'd0, 4'd0, 7'd0);
        #1;
        check("rr_exec_r1_ready", 32'(r1_ready), 32'd0);
        step();
        check_rsp("rr_or", 1'b0, 32'hFF0F_FF0F, 1'b1, 1'b0);
        check("rr_hold_r1_ready", 32'(r1_ready), 32'd0);
        r_rsp_ready = 1'b1;
        #1;
        check("rr_b2b_r1_ready", 32'(r1_ready), 32'd1);
        step();
        drive_r1(1'b0, 32'd0, 32'd0, 4'd0);
        r_rsp_ready = 1'b0;
        check("rr_b2b_state", 32'(r_state), 32'd1);
        check("rr_b2b_valid", 32'(r_rsp_valid), 32'd0);
        step();
        check_rsp("rr_and", 1'b1, 32'h0F00_0F00, 1'b0, 1'b0);
        r_rsp_ready = 1'b1;
        step();
        r_rsp_ready = 1'b0;

        // Backpressure on add 0xFFFFFFFF + 1
        drive_r0(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 7'd0);
        step();
        drive_r0(1'b0, 32'd0, 32'd0, 4'd0, 7'd0);
        step();
        drive_r0(1'b1, 32'h1234_5678, 32'd1, 4'd0, 7'd0);
        drive_r1(1'b1, 32'h1234_5678, 32'd2, 4'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_rsp("bp_hold", 1'b0, 32'd0, 1'b0, 1'b1);
            check("bp_r0_ready", 32'(r0_ready), 32'd0);
            check("bp_r1_ready", 32'(r1_ready), 32'd0);
            step();
        end
        drive_r0(1'b0, 32'd0, 32'd0, 4'd0, 7'd0);
        drive_r1(1'b0, 32'd0, 32'd0, 4'd0);
        r_rsp_ready = 1'b1;
        step();
        r_rsp_ready = 1'b0;
        check("bp_release_state", 32'(r_state), 32'd0);

        // Reset during EXEC drops the op; then sra
        drive_r0(1'b1, 32'h0000_0005, 32'h0000_0007, 4'd0, 7'd0);
        step();
        drive_r0(1'b0, 32'd0, 32'd0, 4'd0, 7'd0);
        check("mid_exec_state", 32'(r_state), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(r_rsp_valid), 32'd0);
        check("mid_rst_state", 32'(r_state), 32'd0);
        step();
        check("mid_rst_no_rsp", 32'(r_rsp_valid), 32'd0);
        drive_r0(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd7, 7'h20);
        step();
        drive_r0(1'b0, 32'd0, 32'd0, 4'd0, 7'd0);
        check("sra_funct7", 32'(r_alu_funct7), 32'h20);
        check("sra_op", 32'(r_alu_op), 32'd7);
        step();
        check_rsp("sra", 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        r_rsp_ready = 1'b1;
        step();
        r_rsp_ready = 1'b0;

        // Fixed priority: req0 held valid, req1 must never be granted
        do_reset();
        f0_valid = 1'b1; f0_in1 = 32'd1; f0_in2 = 32'd2; f0_ctl = 14'd0;
        f1_valid = 1'b1; f1_in1 = 32'd9; f1_in2 = 32'd4; f1_ctl = 14'd1;
        f_rsp_ready = 1'b1;
        #1;
        check("fp_first_r0_ready", 32'(f0_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("fp_r1_ready", 32'(f1_ready), 32'd0);
            if (f_rsp_valid) begin
                check("fp_rsp_id", 32'(f_rsp_id), 32'd0);
                check("fp_rsp_result", f_rsp_result, 32'd3);
            end
            step();
        end
        f0_valid = 1'b0;
        f1_valid = 1'b0;
        f_rsp_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
